// File: rtl/draw_sprites_n.sv
`default_nettype none
// ============================================================================
// Module      : draw_sprites_n
// Description : Multi-sprite overlay stage for the VGA pipeline. Draws up to
//               NUM_SPR sprites from one shared synchronous sprite ROM with
//               fixed priority (index 0 highest), per-sprite enable, mirror
//               and ROM base. Sprite attributes are latched at the start of
//               vertical blanking. Latency is 2 clocks for every out_* signal.
//               Optional macro SPRITE_COLLISION_EN enables per-frame
//               bounding-box overlap reporting on 'collide'.
// Revision    : 1.0 - initial release
// ============================================================================
module draw_sprites_n #(
  parameter int          NUM_SPR = 4,
  parameter int          SPR_W   = 32,
  parameter int          SPR_H   = 32,
  parameter int          ADDR_W  = 16,
  parameter logic [11:0] TRANSP  = 12'hF0F
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [10:0]               in_hcount,
  input  logic [10:0]               in_vcount,
  input  logic                      in_hsync,
  input  logic                      in_vsync,
  input  logic                      in_hblnk,
  input  logic                      in_vblnk,
  input  logic [11:0]               in_rgb,
  input  logic [NUM_SPR*11-1:0]     spr_xpos,
  input  logic [NUM_SPR*11-1:0]     spr_ypos,
  input  logic [NUM_SPR-1:0]        spr_en,
  input  logic [NUM_SPR-1:0]        spr_mirror,
  input  logic [NUM_SPR*ADDR_W-1:0] spr_base,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [11:0]               rom_rgb,
  output logic [10:0]               out_hcount,
  output logic [10:0]               out_vcount,
  output logic                      out_hsync,
  output logic                      out_vsync,
  output logic                      out_hblnk,
  output logic                      out_vblnk,
  output logic [11:0]               out_rgb,
  output logic                      frame_tick,
  output logic [NUM_SPR-1:0]        collide
);

  localparam int COL_W = $clog2(SPR_W);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t                    r_state, w_state_nxt;
  logic                      r_vblnk_d;
  logic                      w_vedge;
  logic [NUM_SPR*11-1:0]     r_sh_x, r_sh_y;
  logic [NUM_SPR-1:0]        r_sh_en, r_sh_mir;
  logic [NUM_SPR*ADDR_W-1:0] r_sh_base;
  logic [NUM_SPR-1:0]        w_hit;
  logic [ADDR_W-1:0]         w_spr_addr [NUM_SPR];
  logic [ADDR_W-1:0]         w_sel_addr;
  logic                      w_any;
  logic                      r_hit;
  logic [10:0]               r1_hcount, r1_vcount;
  logic                      r1_hsync, r1_vsync, r1_hblnk, r1_vblnk;
  logic [11:0]               r1_rgb;
  logic [11:0]               w_hc, w_vc;

  assign w_vedge = in_vblnk & ~r_vblnk_d;
  assign w_hc    = {1'b0, in_hcount};
  assign w_vc    = {1'b0, in_vcount};

  // Per-sprite bounding-box test and ROM address; 12-bit math keeps sprites
  // near column 2047 from wrapping back to column 0.
  for (genvar gi = 0; gi < NUM_SPR; gi++) begin : g_spr
    logic [11:0] w_x, w_y, w_dx, w_col, w_row;
    assign w_x   = {1'b0, r_sh_x[11*gi +: 11]};
    assign w_y   = {1'b0, r_sh_y[11*gi +: 11]};
    assign w_dx  = w_hc - w_x;
    assign w_col = r_sh_mir[gi] ? (12'(SPR_W - 1) - w_dx) : w_dx;
    assign w_row = w_vc - w_y;
    assign w_hit[gi] = (r_state == S_ACTIVE) && r_sh_en[gi] && !in_hblnk && !in_vblnk &&
                       (w_hc >= w_x) && (w_hc < w_x + 12'(SPR_W)) &&
                       (w_vc >= w_y) && (w_vc < w_y + 12'(SPR_H));
    assign w_spr_addr[gi] = r_sh_base[ADDR_W*gi +: ADDR_W] +
                            (ADDR_W'(w_row) << COL_W) + ADDR_W'(w_col);
  end

  // Lowest-index hit wins; with no hit the ROM address is held.
  always_comb begin
    w_any      = 1'b0;
    w_sel_addr = rom_addr;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any      = 1'b1;
        w_sel_addr = w_spr_addr[i];
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Leave IDLE on the first vertical blanking edge; stay ACTIVE afterwards.
  always_comb begin
    w_state_nxt = r_state;
    if (w_vedge) w_state_nxt = S_ACTIVE;
  end

  // Shadow attribute capture and frame_tick on the vblnk rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vblnk_d  <= 1'b0;
      frame_tick <= 1'b0;
      r_sh_x     <= '0;
      r_sh_y     <= '0;
      r_sh_en    <= '0;
      r_sh_mir   <= '0;
      r_sh_base  <= '0;
    end else begin
      r_vblnk_d  <= in_vblnk;
      frame_tick <= w_vedge;
      if (w_vedge) begin
        r_sh_x    <= spr_xpos;
        r_sh_y    <= spr_ypos;
        r_sh_en   <= spr_en;
        r_sh_mir  <= spr_mirror;
        r_sh_base <= spr_base;
      end
    end
  end

  // Stage 1: ROM address, hit flag and delayed timing/background.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_addr  <= '0;
      r_hit     <= 1'b0;
      r1_hcount <= '0;
      r1_vcount <= '0;
      r1_hsync  <= 1'b0;
      r1_vsync  <= 1'b0;
      r1_hblnk  <= 1'b0;
      r1_vblnk  <= 1'b0;
      r1_rgb    <= '0;
    end else begin
      rom_addr  <= w_sel_addr;
      r_hit     <= w_any;
      r1_hcount <= in_hcount;
      r1_vcount <= in_vcount;
      r1_hsync  <= in_hsync;
      r1_vsync  <= in_vsync;
      r1_hblnk  <= in_hblnk;
      r1_vblnk  <= in_vblnk;
      r1_rgb    <= in_rgb;
    end
  end

  // Stage 2: mix ROM colour over background unless transparent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_hcount <= '0;
      out_vcount <= '0;
      out_hsync  <= 1'b0;
      out_vsync  <= 1'b0;
      out_hblnk  <= 1'b0;
      out_vblnk  <= 1'b0;
      out_rgb    <= '0;
    end else begin
      out_hcount <= r1_hcount;
      out_vcount <= r1_vcount;
      out_hsync  <= r1_hsync;
      out_vsync  <= r1_vsync;
      out_hblnk  <= r1_hblnk;
      out_vblnk  <= r1_vblnk;
      out_rgb    <= (r_hit && (rom_rgb != TRANSP)) ? rom_rgb : r1_rgb;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPR-1:0] r_acc;
  logic               w_multi;

  // More than one bit set means at least two sprites cover this pixel.
  assign w_multi = |(w_hit & (w_hit - NUM_SPR'(1)));

  // Accumulate overlaps over a frame; publish and clear at the vblnk edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc   <= '0;
      collide <= '0;
    end else if (w_vedge) begin
      collide <= r_acc;
      r_acc   <= '0;
    end else if (w_multi) begin
      r_acc   <= r_acc | w_hit;
    end
  end
`else
  assign collide = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_draw_sprites_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_draw_sprites_n
// Description : Self-checking bench for draw_sprites_n. A frame-level model
//               predicts every output each cycle; directed pixels also carry
//               hand-computed ROM address and colour expectations.
//               Honours SPRITE_COLLISION_EN for the collide expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_draw_sprites_n;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [10:0]   in_hcount = '0, in_vcount = '0;
  logic          in_hsync = 1'b0, in_vsync = 1'b0, in_hblnk = 1'b1, in_vblnk = 1'b0;
  logic [11:0]   in_rgb = '0;
  logic [N*11-1:0] spr_xpos = '0, spr_ypos = '0;
  logic [N-1:0]  spr_en = '0, spr_mirror = '0;
  logic [N*16-1:0] spr_base = '0;
  logic [15:0]   rom_addr;
  logic [11:0]   rom_rgb;
  logic [10:0]   out_hcount, out_vcount;
  logic          out_hsync, out_vsync, out_hblnk, out_vblnk;
  logic [11:0]   out_rgb;
  logic          frame_tick;
  logic [N-1:0]  collide;
  logic [15:0]   transp_addr = 16'hFFFF;

  int checks = 0;
  int errors = 0;

  draw_sprites_n #(.NUM_SPR(N), .SPR_W(32), .SPR_H(32), .ADDR_W(16), .TRANSP(12'hF0F)) dut (
    .clk(clk), .rst(rst),
    .in_hcount(in_hcount), .in_vcount(in_vcount),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
    .in_rgb(in_rgb),
    .spr_xpos(spr_xpos), .spr_ypos(spr_ypos), .spr_en(spr_en), .spr_mirror(spr_mirror),
    .spr_base(spr_base),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .out_hcount(out_hcount), .out_vcount(out_vcount),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_hblnk(out_hblnk), .out_vblnk(out_vblnk),
    .out_rgb(out_rgb), .frame_tick(frame_tick), .collide(collide)
  );

  always #5 clk = ~clk;

  // Sprite ROM contents: low 12 address bits plus a per-4K-bank offset,
  // with one selectable word forced to the transparent colour.
  function automatic logic [11:0] romw(input logic [15:0] a);
    return (a == transp_addr) ? 12'hF0F : 12'(a[11:0] + {a[15:12], 8'h00});
  endfunction

  assign rom_rgb = romw(rom_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int          sh_x[N], sh_y[N], sh_base[N];
  bit          sh_en[N], sh_mir[N];
  bit          m_active, m_prev_vb;
  logic [10:0] s1_hc, s1_vc;
  logic        s1_hs, s1_vs, s1_hb, s1_vb, s1_hit;
  logic [11:0] s1_rgb;
  logic [15:0] s1_addr;
  logic [10:0] e_hc, e_vc;
  logic        e_hs, e_vs, e_hb, e_vb, e_ft;
  logic [11:0] e_rgb;
  logic [N-1:0] e_col, acc;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_base[i] = 0; sh_en[i] = 0; sh_mir[i] = 0;
    end
    m_active = 0; m_prev_vb = 0;
    s1_hc = '0; s1_vc = '0; s1_hs = 0; s1_vs = 0; s1_hb = 0; s1_vb = 0;
    s1_hit = 0; s1_rgb = '0; s1_addr = '0;
    e_hc = '0; e_vc = '0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0; e_ft = 0;
    e_rgb = '0; e_col = '0; acc = '0;
  endtask

  task automatic m_step();
    logic [11:0]  rw;
    int           win, nh, h, v, col, a;
    logic [N-1:0] hm;
    rw    = romw(s1_addr);
    e_hc  = s1_hc; e_vc = s1_vc; e_hs = s1_hs; e_vs = s1_vs; e_hb = s1_hb; e_vb = s1_vb;
    e_rgb = (s1_hit && rw != 12'hF0F) ? rw : s1_rgb;
    win = -1; nh = 0; hm = '0; a = 0;
    h = int'(in_hcount); v = int'(in_vcount);
    for (int i = 0; i < N; i++) begin
      if (m_active && sh_en[i] && !in_hblnk && !in_vblnk &&
          h >= sh_x[i] && h < sh_x[i] + 32 && v >= sh_y[i] && v < sh_y[i] + 32) begin
        hm[i] = 1'b1;
        nh++;
        if (win < 0) begin
          win = i;
          col = sh_mir[i] ? 31 - (h - sh_x[i]) : h - sh_x[i];
          a   = sh_base[i] + (v - sh_y[i]) * 32 + col;
        end
      end
    end
    s1_hc = in_hcount; s1_vc = in_vcount; s1_hs = in_hsync; s1_vs = in_vsync;
    s1_hb = in_hblnk; s1_vb = in_vblnk; s1_rgb = in_rgb; s1_hit = (win >= 0);
    if (win >= 0) s1_addr = 16'(a);
    if (in_vblnk && !m_prev_vb) begin
      e_ft = 1;
      for (int i = 0; i < N; i++) begin
        sh_x[i]    = int'(spr_xpos[11*i +: 11]);
        sh_y[i]    = int'(spr_ypos[11*i +: 11]);
        sh_base[i] = int'(spr_base[16*i +: 16]);
        sh_en[i]   = spr_en[i];
        sh_mir[i]  = spr_mirror[i];
      end
      m_active = 1;
`ifdef SPRITE_COLLISION_EN
      e_col = acc;
`endif
      acc = '0;
    end else begin
      e_ft = 0;
      if (nh >= 2) acc = acc | hm;
    end
    m_prev_vb = in_vblnk;
  endtask

  // Every-cycle comparison against the model, 1 ns after the clock edge.
  initial begin
    m_reset();
    forever begin
      @(posedge clk);
      if (!rst) m_reset();
      else m_step();
      #1;
      if (rst) begin
        chk("out_rgb", 64'(out_rgb), 64'(e_rgb));
        chk("out_timing", 64'({out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk}),
            64'({e_hc, e_vc, e_hs, e_vs, e_hb, e_vb}));
        chk("rom_addr", 64'(rom_addr), 64'(s1_addr));
        chk("frame_tick", 64'(frame_tick), 64'(e_ft));
        chk("collide", 64'(collide), 64'(e_col));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_spr(input int i, input int x, input int y, input int base,
                         input bit en, input bit mir);
    spr_xpos[11*i +: 11] = 11'(x);
    spr_ypos[11*i +: 11] = 11'(y);
    spr_base[16*i +: 16] = 16'(base);
    spr_en[i]            = en;
    spr_mirror[i]        = mir;
  endtask

  task automatic drive_pix(input int h, input int v, input logic [11:0] rgb);
    in_hcount = 11'(h); in_vcount = 11'(v);
    in_hsync  = in_hcount[0]; in_vsync = in_vcount[0];
    in_hblnk  = 1'b0; in_vblnk = 1'b0; in_rgb = rgb;
  endtask

  // Drive one visible pixel, then a blanked filler; check address after one
  // edge and mixed colour after two.
  task automatic pix_chk(input int h, input int v, input logic [11:0] rgb,
                         input bit do_addr, input logic [15:0] exp_addr,
                         input logic [11:0] exp_rgb);
    @(negedge clk);
    drive_pix(h, v, rgb);
    @(posedge clk); #2;
    if (do_addr) chk("lit_rom_addr", 64'(rom_addr), 64'(exp_addr));
    @(negedge clk);
    in_hblnk = 1'b1; in_rgb = 12'h0AA;
    @(posedge clk); #2;
    chk("lit_out_rgb", 64'(out_rgb), 64'(exp_rgb));
  endtask

  task automatic vblank();
    @(negedge clk);
    in_vblnk = 1'b1; in_hblnk = 1'b1; in_hcount = '0; in_vcount = 11'd600; in_rgb = 12'h055;
    @(posedge clk); #2;
    chk("lit_frame_tick", 64'(frame_tick), 64'd1);
    repeat (2) @(negedge clk);
    in_vblnk = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Before the first vblank edge nothing is drawn.
    set_spr(0, 100, 50, 0, 1'b1, 1'b0);
    pix_chk(100, 50, 12'h123, 1'b1, 16'd0, 12'h123);

    // Single sprite.
    vblank();
    pix_chk(100, 50, 12'h123, 1'b1, 16'd0,    12'h000);
    pix_chk(131, 81, 12'h123, 1'b1, 16'd1023, 12'h3FF);
    pix_chk(132, 50, 12'h456, 1'b1, 16'd1023, 12'h456);

    // Mirror, then a transparent ROM word at the mirrored address.
    spr_mirror[0] = 1'b1;
    vblank();
    pix_chk(100, 50, 12'h123, 1'b1, 16'd31, 12'h01F);
    transp_addr = 16'd31;
    pix_chk(100, 50, 12'h321, 1'b1, 16'd31, 12'h321);
    transp_addr = 16'hFFFF;

    // Priority: sprite 0 over sprite 2; disabling applies next frame only.
    set_spr(0, 200, 200, 0,    1'b1, 1'b0);
    set_spr(2, 200, 200, 4096, 1'b1, 1'b0);
    vblank();
    pix_chk(205, 203, 12'h777, 1'b1, 16'd101, 12'h065);
    spr_en[0] = 1'b0;
    pix_chk(205, 203, 12'h777, 1'b1, 16'd101, 12'h065);
    vblank();
    pix_chk(205, 203, 12'h777, 1'b1, 16'd4197, 12'h165);

    // Frame latching of a mid-frame position change.
    spr_xpos[11*2 +: 11] = 11'd300;
    pix_chk(205, 203, 12'h777, 1'b1, 16'd4197, 12'h165);
    vblank();
    pix_chk(205, 203, 12'h888, 1'b1, 16'd4197, 12'h888);
    pix_chk(305, 203, 12'h888, 1'b1, 16'd4197, 12'h165);

    // Asynchronous reset mid-line.
    @(negedge clk);
    drive_pix(305, 203, 12'h999);
    #2 rst = 1'b0;
    #1;
    chk("rst_out_rgb", 64'(out_rgb), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_timing", 64'({out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk}), 64'd0);
    chk("rst_frame_tick", 64'(frame_tick), 64'd0);
    chk("rst_collide", 64'(collide), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pix_chk(305, 203, 12'h999, 1'b1, 16'd0, 12'h999);
    vblank();
    pix_chk(305, 203, 12'h999, 1'b1, 16'd4197, 12'h165);

    // Collision: sprites 1 and 3 share column 431; sprite 0 sits at the
    // right edge of the counter range and must not wrap to column 0.
    spr_en = '0;
    set_spr(0, 2040, 400, 0,     1'b1, 1'b0);
    set_spr(1, 400,  400, 8192,  1'b1, 1'b0);
    set_spr(3, 431,  400, 12288, 1'b1, 1'b0);
    vblank();
    pix_chk(431,  400, 12'hABC, 1'b1, 16'd8223, 12'h21F);
    pix_chk(2045, 400, 12'hABC, 1'b1, 16'd5,    12'h005);
    pix_chk(3,    400, 12'hABD, 1'b1, 16'd5,    12'hABD);
    set_spr(3, 500, 400, 12288, 1'b1, 1'b0);
    vblank();
`ifdef SPRITE_COLLISION_EN
    chk("lit_collide_overlap", 64'(collide), 64'(4'b1010));
`else
    chk("lit_collide_overlap", 64'(collide), 64'd0);
`endif
    pix_chk(431, 400, 12'hABC, 1'b1, 16'd8223, 12'h21F);
    vblank();
    chk("lit_collide_clear", 64'(collide), 64'd0);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/draw_sprites_n.md
# draw_sprites_n

Parametrised multi-sprite overlay stage for the game VGA pipeline: the successor to the single-player drawing stage, rendering up to NUM_SPR independent sprites from one shared synchronous sprite ROM. Sits between the map layer and the content/HUD layer. Adds per-sprite enable, mirroring and ROM base, fixed priority, frame-synchronous position latching and optional overlap detection.

## Interface
Parameters:
- NUM_SPR, 4, sprite count (1..8); index 0 has the highest priority
- SPR_W, 32, sprite width in pixels (power of two)
- SPR_H, 32, sprite height in pixels
- ADDR_W, 16, sprite ROM address width
- TRANSP, 12'hF0F, ROM colour treated as transparent

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- in_hcount, in_vcount  in  11 each  pixel counters from the previous stage
- in_hsync, in_vsync, in_hblnk, in_vblnk  in  1 each  timing from the previous stage
- in_rgb  in  12  background colour
- spr_xpos, spr_ypos  in  NUM_SPR*11  packed top-left positions; sprite i is at [11*i +: 11]
- spr_en  in  NUM_SPR  per-sprite enable
- spr_mirror  in  NUM_SPR  1 = horizontal mirror (facing left)
- spr_base  in  NUM_SPR*ADDR_W  per-sprite ROM base address
- rom_addr  out  ADDR_W  sprite ROM address
- rom_rgb  in  12  ROM data, valid one cycle after rom_addr
- out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, out_rgb  out  same widths as the inputs  delayed timing and mixed colour
- frame_tick  out  1  one-cycle pulse when shadow registers load
- collide  out  NUM_SPR  bit i set if sprite i overlapped another sprite during the last frame

## Operation
- Shadow registers: spr_xpos/ypos/en/mirror/base are captured on the first cycle in_vblnk is high (0→1 edge). The same cycle asserts frame_tick. Hit logic uses only the shadow copies, so there is no mid-frame tearing.
- Hit test for sprite i, with 12-bit unsigned arithmetic and no wrap:
  - shadow_en[i] and not in_hblnk and not in_vblnk
  - in_hcount ≥ x and in_hcount < x+SPR_W
  - in_vcount ≥ y and in_vcount < y+SPR_H
  - Sprites partially past 1023/767 are clipped naturally. A sprite at x ≥ 2048−SPR_W never wraps to column 0.
- Select: the lowest-index hit wins.
  - col = hcount−x, or SPR_W−1−(hcount−x) when mirrored.
  - row = vcount−y.
  - rom_addr = base + row*SPR_W + col, truncated to ADDR_W.
  - No hit: rom_addr holds its previous value.
- Mix: a hit pixel with rom_rgb ≠ TRANSP outputs rom_rgb. Otherwise it outputs the delayed in_rgb. Transparent pixels of the winning sprite show the background, not lower-priority sprites.
- States per frame: IDLE (reset) → ACTIVE after the first vblnk edge. Before the first edge nothing is drawn; in_* passes through delayed.

## Timing
- Stage 1 registers rom_addr, the hit flag and the delayed timing/rgb. The ROM supplies its data in cycle 2. Stage 2 registers out_*.
- Fixed latency of 2 cycles for every out_* signal relative to in_*, including in blanking.
- frame_tick and the shadow load occur on the same clock edge that registers the vblnk edge. A position change in the same cycle as that edge is captured.
- Reset (asynchronous, at any point):
  - all out_*, rom_addr, frame_tick, collide and the shadow registers go to 0
  - the FSM returns to IDLE
  - a frame in progress is abandoned
  - output resumes after the next vblnk edge

## Configuration
- SPRITE_COLLISION_EN defined:
  - During a frame, any pixel where two or more sprites hit sets the accumulator bit of every hitting sprite. Transparency is ignored; the bounding box is used.
  - On the vblnk edge, collide ← accumulator and the accumulator clears. The accumulator always clears, even when no bit was set.
  - collide therefore reports the previous frame and is stable for a whole frame.
- Not defined: there is no accumulator logic and collide is tied to 0.

## Test plan
- Reset: assert rst=0 mid-line → all outputs read 0 immediately. Release it and run 1 frame → out_rgb equals in_rgb delayed by exactly 2 clocks.
- Single sprite: sprite 0 at (100,50), base 0, ROM pattern data = address. Pixel (100,50) → rom_addr 0. Pixel (131,81) → rom_addr 1023. Pixel (132,50) shows background.
- Mirror: repeat the single-sprite case with spr_mirror[0]=1 → pixel (100,50) uses rom_addr 31. Then set a ROM word to 12'hF0F → background appears at that pixel.
- Priority: sprites 0 and 2 both at (200,200), with different bases → sprite 0's pixels are drawn. Disable sprite 0 → sprite 2's pixels are drawn from the next frame only.
- Frame latching: change spr_xpos mid-frame → the current frame is unchanged. The new position appears after frame_tick.
- Collision (macro on): sprites 1 and 3 overlap by 1 pixel in frame N → collide = 4'b1010 from the vblnk edge after frame N. It reads 0 one frame after they separate. With the macro off, collide stays 0.
